// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR step function for the
// multi-channel LFSR/CRC bus engine.
package lfsr_pkg;

  localparam int MAXW = 32;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_CLEAR   = 4'h1,
    OP_STEP1   = 4'h2,
    OP_STEPN   = 4'h3,
    OP_SHIFTIN = 4'h4,
    OP_LOAD    = 4'h5,
    OP_SETPOLY = 4'h6
  } op_e;

  typedef enum logic {
    IDLE,
    RUN
  } fsm_e;

  // Operands arrive zero-extended, so the tap XOR
  // only sees real register bits.
  function automatic logic [MAXW-1:0] lfsr_next(
    input logic [MAXW-1:0] s,
    input logic [MAXW-1:0] p,
    input logic            din
  );
    return {s[MAXW-2:0], ^(s & p) ^ din};
  endfunction

endpackage

// File: rtl/lfsr_bus_engine_step.sv
// Combinational Fibonacci next-state for one
// channel register.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] poly,
  input  logic             din,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = WIDTH'(lfsr_next(
    MAXW'(state), MAXW'(poly), din));

endmodule

// File: rtl/lfsr_bus_engine.sv
// Bus-mapped multi-channel LFSR/CRC engine with a
// shared runtime polynomial and a step-N sequencer.
module lfsr_bus_engine
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter logic [WIDTH-1:0] POLY = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 8'h01,
  parameter int CW    = 8,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW   = (WIDTH > CW) ? WIDTH : CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [CHW-1:0]   cmd_ch,
  input  logic [DW-1:0]    cmd_data,
  input  logic [CHW-1:0]   rd_ch,
  output logic [WIDTH-1:0] rd_data,
  output logic             sdo,
  output logic             zero_flag,
  output logic             seed_flag,
  output logic             done
);

  fsm_e             state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CHW-1:0]   run_ch, run_ch_n, sch;
  logic [WIDTH-1:0] st [NCH];
  logic [WIDTH-1:0] poly, poly_n;
  logic [WIDTH-1:0] cur, nxt, wdata;
  logic [CW-1:0]    n_op;
  logic             we, din, done_n, acc;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign n_op      = cmd_data[CW-1:0];
  assign cmd_ready = (state == IDLE);
  assign acc       = sel & cmd_valid & cmd_ready;

  // One stepper, shared between the command path
  // and the latched channel of a running STEPN.
  assign sch = cmd_ready ? cmd_ch : run_ch;
  assign cur = st[sch];
  assign din = cmd_ready & (op == OP_SHIFTIN)
             & cmd_data[0];

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .state (cur),
    .poly  (poly),
    .din   (din),
    .nxt   (nxt)
  );

  assign rd_data   = st[rd_ch];
  assign sdo       = rd_data[WIDTH-1];
  assign zero_flag = (rd_data == '0);
  assign seed_flag = (rd_data == SEED);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    run_ch_n = run_ch;
    poly_n   = poly;
    done_n   = 1'b0;
    we       = 1'b0;
    wdata    = nxt;
    unique case (state)
      IDLE: begin
        if (acc) begin
          unique case (op)
            OP_CLEAR: begin
              we    = 1'b1;
              wdata = SEED;
            end
            OP_STEP1, OP_SHIFTIN: we = 1'b1;
            OP_STEPN: begin
              if (n_op != '0) begin
                state_n  = RUN;
                cnt_n    = n_op;
                run_ch_n = cmd_ch;
              end
            end
            OP_LOAD: begin
              we    = 1'b1;
              wdata = cmd_data[WIDTH-1:0];
            end
            OP_SETPOLY: poly_n = cmd_data[WIDTH-1:0];
            default: ;
          endcase
        end
      end
      RUN: begin
        we    = 1'b1;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      run_ch <= '0;
      poly   <= POLY;
      done   <= 1'b0;
      for (int i = 0; i < NCH; i++) st[i] <= SEED;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      run_ch <= run_ch_n;
      poly   <= poly_n;
      done   <= done_n;
      if (we) st[sch] <= wdata;
    end
  end

endmodule

// File: doc/lfsr_bus_engine.md
Name: lfsr_bus_engine

Overview:
- Bus-mapped, multi-channel LFSR/CRC register engine. Successor to the fixed 6-bit, single-channel decode-and-step PAL state machine.
- Generalised in register width, channel count and polynomial, which is runtime-writable.
- Adds a multi-cycle step-N command with a ready/busy handshake, serial CRC bit injection and status flags.
- Sits behind the I/O address decoder. The decoder supplies `sel`. A command nibble (former BA7..BA4 field) chooses the operation.

Parameters:
- WIDTH, 8: LFSR register width in bits, 2..32.
- NCH, 4: number of independent channels, 1..16.
- POLY, 8'hB8: reset tap mask. Bit i set means state[i] feeds the XOR. Width WIDTH.
- SEED, 8'h01: reset/CLEAR value for every channel. Width WIDTH.
- CW, 8: width of the step-count operand.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- sel  in  1  chip select from the address decoder; commands ignored when 0.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  4  operation code.
- cmd_ch  in  clog2(NCH) (min 1)  target channel.
- cmd_data  in  max(WIDTH,CW)  operand.
- rd_ch  in  clog2(NCH) (min 1)  read channel select.
- rd_data  out  WIDTH  state of channel rd_ch (combinational).
- sdo  out  1  MSB of state[rd_ch]; serial read bit.
- zero_flag  out  1  state[rd_ch] == 0 (lock-up indicator).
- seed_flag  out  1  state[rd_ch] == SEED (period-complete indicator).
- done  out  1  one-cycle pulse when a STEPN finishes.

Behaviour:
- Reset (rst_n=0 at an edge):
  - every channel state <= SEED; poly <= POLY.
  - FSM <= IDLE; counter <= 0; done <= 0.
  - cmd_ready = 1 after reset.
  - Reset mid-STEPN aborts it. No done pulse is issued.
- Step function (Fibonacci, left shift):
  - fb = ^(state & poly) ^ din.
  - next = {state[WIDTH-2:0], fb}.
  - din = 0 except for SHIFTIN.
- Accept: the command is taken on an edge with sel & cmd_valid & cmd_ready. Otherwise nothing changes.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 CLEAR: state[ch] <= SEED.
  - 0x2 STEP1: one step on state[ch].
  - 0x3 STEPN: N = cmd_data[CW-1:0] steps on state[ch].
  - 0x4 SHIFTIN: one step with din = cmd_data[0].
  - 0x5 LOAD: state[ch] <= cmd_data[WIDTH-1:0].
  - 0x6 SETPOLY: poly <= cmd_data[WIDTH-1:0]. Shared by all channels; affects subsequent steps only.
  - 0x7..0xF: reserved, treated as NOP.
- Single-cycle ops: result is visible on rd_data the cycle after the accept edge. cmd_ready stays 1.
- FSM IDLE/RUN:
  - STEPN with N>0: counter <= N, latch channel, IDLE->RUN. No step on the accept edge.
  - Each RUN edge: one step on the latched channel, counter decrements.
  - At counter==1 that edge steps, returns to IDLE, and done=1 for the following cycle.
  - STEPN with N=0 is a NOP: no busy, no done.
- cmd_ready = (FSM==IDLE). Low for exactly N cycles. Commands presented while busy are held by the master, not dropped or queued.
- Width rules: operand upper bits beyond WIDTH/CW are ignored. Counter wraps never; the max N = 2^CW-1.
- Lock-up: all-zero state with poly step stays zero, and zero_flag=1. Only LOAD, CLEAR or SHIFTIN(1) escape.
- rd_data and the flags track the current register, including mid-RUN. rd_ch may differ from the busy channel.

Decomposition:
- Shared package `lfsr_pkg`:
  - opcode enum (OP_NOP..OP_SETPOLY);
  - FSM state enum {IDLE, RUN};
  - `lfsr_next(state, poly, din)` function.
- One sub-module, `lfsr_step` (combinational next-state), instanced once and muxed onto the selected/latched channel.

Test Plan:
- Reset, then rd_ch=0: rd_data=0x01, seed_flag=1, cmd_ready=1, done=0.
- STEP1 ch0 from 0x01 -> 0x02. LOAD ch1 0x80 then STEP1 -> 0x01. ch0 is unaffected.
- STEPN ch0 N=8 from 0x01:
  - cmd_ready low for 8 cycles; a concurrent CLEAR is held off;
  - final 0x1C; done pulses once; intermediate sequence 02,04,08,11,23,47,8E,1C.
- LOAD ch2 0x00, STEP1: stays 0x00, zero_flag=1. SHIFTIN din=1 -> 0x01.
- SETPOLY 0x00, LOAD 0x81, STEP1 -> 0x02. STEPN N=0 -> no busy cycle, no done.
- Reset asserted mid-STEPN (after 3 steps): all channels 0x01, poly 0xB8, cmd_ready=1, no done pulse.
